// File: rtl/eighth_phase_pack.sv
// rtl/eighth_phase_pack.sv - FP add/sub post-rounding renormalise, range check and IEEE-754 pack
// Optional build macro EIGHTH_PHASE_SATURATE_EN: overflow packs the largest finite value instead of infinity.
module eighth_phase_pack #(
   parameter int W_Sgf = 23,
   parameter int W_Exp = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   ack,
   input  logic [W_Sgf+1:0]       Sgf_Ready,
   input  logic [W_Exp-1:0]       Exp_In,
   input  logic                   Sgn_M,
   output logic [W_Exp+W_Sgf:0]   final_result,
   output logic                   overflow_flag,
   output logic                   underflow_flag,
   output logic                   zero_flag,
   output logic                   busy,
   output logic                   done
);

   typedef enum logic [1:0] {IDLE, ADJUST, CHECK, DONE} state_t;

   // Widened exponent threshold: anything at or above the all-ones field is out of range.
   localparam logic [W_Exp:0] EXP_MAX = {1'b0, {W_Exp{1'b1}}};

   state_t                 state_q, state_d;
   logic [W_Sgf+1:0]       sgf_q, sgf_d;
   logic [W_Exp-1:0]       exp_in_q, exp_in_d;
   logic                   sgn_q, sgn_d;
   logic [W_Sgf-1:0]       frac_q, frac_d;
   logic [W_Exp:0]         exp_w_q, exp_w_d;
   logic [W_Exp+W_Sgf:0]   result_q, result_d;
   logic                   ovf_q, ovf_d;
   logic                   unf_q, unf_d;
   logic                   zro_q, zro_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [W_Exp+W_Sgf:0]   ovf_value;

`ifdef EIGHTH_PHASE_SATURATE_EN
   assign ovf_value = {sgn_q, {(W_Exp-1){1'b1}}, 1'b0, {W_Sgf{1'b1}}};
`else
   assign ovf_value = {sgn_q, {W_Exp{1'b1}}, {W_Sgf{1'b0}}};
`endif

   always_comb begin
      state_d  = state_q;
      sgf_d    = sgf_q;
      exp_in_d = exp_in_q;
      sgn_d    = sgn_q;
      frac_d   = frac_q;
      exp_w_d  = exp_w_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      zro_d    = zro_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               sgf_d    = Sgf_Ready;
               exp_in_d = Exp_In;
               sgn_d    = Sgn_M;
               state_d  = ADJUST;
            end
         end
         ADJUST: begin
            if (sgf_q[W_Sgf+1]) begin
               frac_d  = sgf_q[W_Sgf:1];
               exp_w_d = {1'b0, exp_in_q} + {{W_Exp{1'b0}}, 1'b1};
            end else begin
               frac_d  = sgf_q[W_Sgf-1:0];
               exp_w_d = {1'b0, exp_in_q};
            end
            state_d = CHECK;
         end
         CHECK: begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
            zro_d = 1'b0;
            if (sgf_q == '0) begin
               result_d = {sgn_q, {(W_Exp+W_Sgf){1'b0}}};
               zro_d    = 1'b1;
            end else if (exp_in_q == '0 || (!sgf_q[W_Sgf+1] && !sgf_q[W_Sgf])) begin
               // Denormal results are flushed to signed zero.
               result_d = {sgn_q, {(W_Exp+W_Sgf){1'b0}}};
               unf_d    = 1'b1;
            end else if (exp_w_q >= EXP_MAX) begin
               result_d = ovf_value;
               ovf_d    = 1'b1;
            end else begin
               result_d = {sgn_q, exp_w_q[W_Exp-1:0], frac_q};
            end
            state_d = DONE;
         end
         DONE: begin
            if (ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         sgf_q    <= '0;
         exp_in_q <= '0;
         sgn_q    <= 1'b0;
         frac_q   <= '0;
         exp_w_q  <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         zro_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sgf_q    <= sgf_d;
         exp_in_q <= exp_in_d;
         sgn_q    <= sgn_d;
         frac_q   <= frac_d;
         exp_w_q  <= exp_w_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         zro_q    <= zro_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign final_result   = result_q;
   assign overflow_flag  = ovf_q;
   assign underflow_flag = unf_q;
   assign zero_flag      = zro_q;
   assign busy           = busy_q;
   assign done           = done_q;

endmodule

// File: tb/tb_eighth_phase_pack.sv
// tb/tb_eighth_phase_pack.sv - scoreboard bench for eighth_phase_pack (single precision)
module tb_eighth_phase_pack;

   logic        clk;
   logic        rst;
   logic        start;
   logic        ack;
   logic [24:0] Sgf_Ready;
   logic [7:0]  Exp_In;
   logic        Sgn_M;
   logic [31:0] final_result;
   logic        overflow_flag;
   logic        underflow_flag;
   logic        zero_flag;
   logic        busy;
   logic        done;

   int total = 0;
   int bad   = 0;

   logic [34:0] sb[$];
   logic        done_prev = 1'b0;
   logic [31:0] held = '0;

`ifdef EIGHTH_PHASE_SATURATE_EN
   localparam logic [31:0] OVF_RES = 32'hFF7FFFFF;
`else
   localparam logic [31:0] OVF_RES = 32'hFF800000;
`endif

   eighth_phase_pack #(.W_Sgf(23), .W_Exp(8)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .ack(ack),
      .Sgf_Ready(Sgf_Ready),
      .Exp_In(Exp_In),
      .Sgn_M(Sgn_M),
      .final_result(final_result),
      .overflow_flag(overflow_flag),
      .underflow_flag(underflow_flag),
      .zero_flag(zero_flag),
      .busy(busy),
      .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   // Monitor: each rising done pops one expected {result, ovf, unf, zero}; while done is held the result must not move.
   always @(negedge clk) begin
      if (done) begin
         if (!done_prev) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 64'd1, 64'd0);
            end else begin
               logic [34:0] e;
               e = sb.pop_front();
               check("result", {32'd0, final_result, overflow_flag, underflow_flag, zero_flag} >> 3, {32'd0, e} >> 3);
               check("flags", {61'd0, overflow_flag, underflow_flag, zero_flag}, {61'd0, e[2:0]});
            end
            held = final_result;
         end else begin
            check("result_hold", {32'd0, final_result}, {32'd0, held});
         end
      end
      done_prev = done;
   end

   task automatic run_op(input logic [24:0] s, input logic [7:0] e, input logic g,
                         input logic [31:0] res, input logic [2:0] fl);
      @(posedge clk); #1;
      Sgf_Ready = s; Exp_In = e; Sgn_M = g; start = 1'b1;
      sb.push_back({res, fl});
      @(posedge clk); #1;
      start = 1'b0;
      Sgf_Ready = '0; Exp_In = '0; Sgn_M = 1'b0;
      check("busy_c1", {63'd0, busy}, 64'd1);
      check("done_c1", {63'd0, done}, 64'd0);
      @(posedge clk); #1;
      check("busy_c2", {63'd0, busy}, 64'd1);
      check("done_c2", {63'd0, done}, 64'd0);
      @(posedge clk); #1;
      check("done_c3", {63'd0, done}, 64'd1);
      check("busy_c3", {63'd0, busy}, 64'd1);
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
      check("done_after_ack", {63'd0, done}, 64'd0);
      check("busy_after_ack", {63'd0, busy}, 64'd0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; ack = 1'b0;
      Sgf_Ready = '0; Exp_In = '0; Sgn_M = 1'b0;
      #2;
      check("rst_result", {32'd0, final_result}, 64'd0);
      check("rst_flags", {59'd0, overflow_flag, underflow_flag, zero_flag, busy, done}, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      // ack outside DONE must be ignored
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
      check("ack_idle_busy", {63'd0, busy}, 64'd0);

      run_op(25'h0C00000, 8'h7F, 1'b0, 32'h3FC00000, 3'b000);
      run_op(25'h1000000, 8'h7F, 1'b0, 32'h40000000, 3'b000);
      run_op(25'h1000000, 8'hFE, 1'b1, OVF_RES,      3'b100);
      run_op(25'h0800000, 8'hFF, 1'b0, OVF_RES & 32'h7FFFFFFF, 3'b100);
      run_op(25'h0000000, 8'h45, 1'b1, 32'h80000000, 3'b001);
      run_op(25'h0800000, 8'h00, 1'b0, 32'h00000000, 3'b010);
      run_op(25'h0400000, 8'h10, 1'b1, 32'h80000000, 3'b010);
      run_op(25'h1FFFFFE, 8'hFD, 1'b0, 32'h7F7FFFFF, 3'b000);

      // Handshake: start held with new operands while busy/done, no ack until cycle 5.
      @(posedge clk); #1;
      Sgf_Ready = 25'h0A00000; Exp_In = 8'h81; Sgn_M = 1'b1; start = 1'b1;
      sb.push_back({32'hC0A00000, 3'b000});
      @(posedge clk); #1;
      Sgf_Ready = 25'h1000000; Exp_In = 8'hFE; Sgn_M = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         if (c >= 3) begin
            check("hs_done", {63'd0, done}, 64'd1);
            check("hs_result", {32'd0, final_result}, {32'd0, 32'hC0A00000});
         end else begin
            check("hs_busy", {63'd0, busy}, 64'd1);
         end
         @(posedge clk); #1;
      end
      start = 1'b0; ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
      check("hs_done_clear", {63'd0, done}, 64'd0);
      check("hs_idle", {63'd0, busy}, 64'd0);
      run_op(25'h0C00000, 8'h80, 1'b0, 32'h40400000, 3'b000);

      // Reset during CHECK: outputs clear at once and the operation never completes.
      @(posedge clk); #1;
      Sgf_Ready = 25'h0C00000; Exp_In = 8'h7F; Sgn_M = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("mid_rst_result", {32'd0, final_result}, 64'd0);
      check("mid_rst_busy", {63'd0, busy}, 64'd0);
      check("mid_rst_done", {63'd0, done}, 64'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_done", {63'd0, done}, 64'd0);
      run_op(25'h1000000, 8'h7F, 1'b1, 32'hC0000000, 3'b000);

      repeat (3) @(posedge clk);
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/eighth_phase_pack.md
Name: eighth_phase_pack

Overview:
- Downstream of the rounding phase in the FP add/sub datapath.
- Consumes the rounded significand (W_Sgf+2 bits, MSB = rounding carry), the pre-rounding exponent and the result sign.
- Performs post-rounding renormalisation, exponent increment, overflow/underflow/zero detection and IEEE-754 packing.
- Multi-cycle FSM with a start/done/ack handshake; the result is held stable until acknowledged.

Parameters:
- W_Sgf, 23, stored fraction width (52 for double).
- W_Exp, 8, exponent field width (11 for double).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  operand-valid strobe; sampled only in IDLE.
- ack  input  1  consumer acknowledge; sampled only in DONE.
- Sgf_Ready  input  W_Sgf+2  rounded significand: [W_Sgf+1] carry, [W_Sgf] hidden one, [W_Sgf-1:0] fraction.
- Exp_In  input  W_Exp  biased exponent before rounding.
- Sgn_M  input  1  result sign.
- final_result  output  W_Exp+W_Sgf+1  packed {sign, exponent, fraction}.
- overflow_flag  output  1  result overflowed.
- underflow_flag  output  1  result flushed to zero because of underflow.
- zero_flag  output  1  exact zero significand.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  result valid; held until ack.

Behaviour:
- Reset (rst=0, asynchronous):
  - state goes to IDLE.
  - final_result, all flags, done and busy are 0.
  - Internal capture registers are 0.
  - Applies mid-operation too: outputs clear immediately, no pending result survives.
- States and transitions:
  - IDLE -> ADJUST on start=1. Sgf_Ready, Exp_In and Sgn_M are captured at that edge.
  - ADJUST -> CHECK unconditionally.
  - CHECK -> DONE unconditionally. The outputs are registered at this edge.
  - DONE -> IDLE on ack=1.
- Latency:
  - done rises after the 3rd rising edge counting the start-capture edge.
  - Example: start high in cycle 0 gives done=1 in cycle 3.
  - done stays 1 until the edge that samples ack=1, then goes to 0.
- start while busy (ADJUST/CHECK/DONE): ignored, with no effect on the in-flight operation. start and ack together in DONE: ack is honoured, start is dropped.
- ack outside DONE: ignored.
- ADJUST arithmetic (the exponent is widened to W_Exp+1 bits so the increment cannot wrap):
  - carry=1: fraction = Sgf[W_Sgf:1], exponent = Exp_In+1.
  - carry=0: fraction = Sgf[W_Sgf-1:0], exponent = Exp_In.
- CHECK priority, highest first:
  1. Zero: captured Sgf_Ready == 0. Result {Sgn_M, 0, 0}, zero_flag=1.
  2. Underflow: Exp_In == 0, or carry=0 and hidden=0. Result {Sgn_M, 0, 0}, underflow_flag=1 (denormals are flushed).
  3. Overflow: widened exponent >= 2^W_Exp-1, which includes Exp_In all-ones. Result {Sgn_M, all-ones, 0} (infinity), overflow_flag=1.
  4. Normal: {Sgn_M, exponent[W_Exp-1:0], fraction}, all flags 0.
- Flags are mutually exclusive.
- final_result and flags hold their value through DONE and IDLE until overwritten at the next CHECK edge.

Optional Feature:
- Macro: EIGHTH_PHASE_SATURATE_EN.
- Defined: overflow yields the largest finite magnitude {Sgn_M, all-ones minus 1, all-ones fraction}. overflow_flag is still 1.
- Undefined: overflow yields signed infinity as specified above.
- All other behaviour is identical in both builds.

Test Plan (single precision defaults):
- Normal value: Sgf_Ready=0x0C00000, Exp_In=0x7F, Sgn_M=0, start pulse in cycle 0 -> done=1 in cycle 3, final_result=0x3FC00000, flags 0, busy=1 in cycles 1-3.
- Rounding carry: Sgf_Ready=0x1000000, Exp_In=0x7F -> final_result=0x40000000, no flags.
- Overflow: Sgf_Ready=0x1000000, Exp_In=0xFE, Sgn_M=1 -> final_result=0xFF800000, overflow_flag=1. With EIGHTH_PHASE_SATURATE_EN: 0xFF7FFFFF, overflow_flag=1.
- Zero and underflow:
  - Sgf_Ready=0, Exp_In=0x45, Sgn_M=1 -> final_result=0x80000000, zero_flag=1.
  - Sgf_Ready=0x0800000, Exp_In=0x00 -> final_result=0x00000000, underflow_flag=1.
- Handshake: second start with different operands in cycles 1-4 without ack -> first result unchanged, done held high. ack in cycle 5 -> done=0 in cycle 6, IDLE. A new start then completes normally.
- Reset mid-operation: rst=0 during CHECK -> outputs 0 asynchronously, state IDLE, done is never asserted for that operation. Next start after rst=1 yields a correct result.
